// File: rtl/ff_write_arbiter_pkg.sv
// Shared types and sizing helpers for the round-robin write arbiter.
// Exists so the arbiter core and its bus interface agree on state encoding and index width.
package ff_arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    WRITE = 1'b1
  } arb_state_t;

  localparam int DEFAULT_N = 4;
  localparam int DEFAULT_W = 8;

  // Index width for N requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ff_write_arbiter_if.sv
// Requester-side bus of the shared-register write arbiter.
// Requesters use the master modport; the arbiter uses the slave modport.
interface ff_write_arbiter_if
  import ff_arb_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = DEFAULT_W
) ();

  localparam int IW = idx_w(N);

  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic [IW-1:0]  owner;
  logic           valid;

  modport master (
    output req,
    output wdata,
    input  gnt,
    input  q,
    input  owner,
    input  valid
  );

  modport slave (
    input  req,
    input  wdata,
    output gnt,
    output q,
    output owner,
    output valid
  );

endinterface

// File: rtl/flipflop_sync.sv
// One-bit register with synchronous clear and clock enable.
// The clear wins over the enable so a reset always empties the shared register.
module flipflop_sync (
  input  logic clk,
  input  logic clr,
  input  logic ena,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= 1'b0;
    end else if (ena) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ff_write_arbiter.sv
// Round-robin arbiter that lets N requesters take turns writing one W-bit register.
// Each grant costs two cycles: ARB picks a winner, WRITE captures its data.
module ff_write_arbiter
  import ff_arb_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = DEFAULT_W
) (
  input  logic               clk,
  input  logic               clr,
  ff_write_arbiter_if.slave  bus
);

  localparam int IW = idx_w(N);

  arb_state_t    r_state;
  arb_state_t    w_state_next;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_winner;
  logic [IW-1:0] r_owner;
  logic          r_valid;
  logic [N-1:0]  r_gnt;

  logic          w_found;
  logic [IW-1:0] w_pick;
  logic          w_launch;
  logic          w_ena;
  logic [W-1:0]  w_d;
  logic [W-1:0]  w_q;

  // Returns {found, index}; scanning downward leaves the entry closest to ptr as the result.
  function automatic logic [IW:0] rr_select(input logic [N-1:0] req, input logic [IW-1:0] ptr);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        res = {1'b1, IW'(idx)};
      end
    end
    return res;
  endfunction

  assign {w_found, w_pick} = rr_select(bus.req, r_ptr);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ARB;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    w_ena        = 1'b0;
    case (r_state)
      ARB: begin
        if (w_found) begin
          w_state_next = WRITE;
          w_launch     = 1'b1;
        end
      end
      WRITE: begin
        w_state_next = ARB;
        w_ena        = 1'b1;
      end
      default: w_state_next = ARB;
    endcase
  end

  // Only the latched winner's lane reaches the register, whatever req does meanwhile.
  always_comb begin
    w_d = bus.wdata[int'(r_winner) * W +: W];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_ptr    <= '0;
      r_winner <= '0;
      r_owner  <= '0;
      r_valid  <= 1'b0;
      r_gnt    <= '0;
    end else begin
      r_gnt <= '0;
      if (w_launch) begin
        r_winner <= w_pick;
        r_gnt    <= N'(1) << w_pick;
      end
      if (w_ena) begin
        r_owner <= r_winner;
        r_valid <= 1'b1;
        r_ptr   <= (r_winner == IW'(N - 1)) ? '0 : r_winner + 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      flipflop_sync u_ff (
        .clk (clk),
        .clr (clr),
        .ena (w_ena),
        .d   (w_d[gi]),
        .q   (w_q[gi])
      );
    end
  endgenerate

  assign bus.q     = w_q;
  assign bus.gnt   = r_gnt;
  assign bus.owner = r_owner;
  assign bus.valid = r_valid;

endmodule

// File: tb/tb_ff_write_arbiter.sv
// Bench for ff_write_arbiter: directed scenarios followed by random requester traffic,
// all compared against a transaction-level model of the arbitration rules.
module tb_ff_write_arbiter;
  import ff_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  ff_write_arbiter_if #(.N(N), .W(W)) bif ();

  ff_write_arbiter #(.N(N), .W(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bif.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pending winner (-1 if none), pointer and visible register state.
  int           m_pend  = -1;
  int           m_ptr   = 0;
  int           m_owner = 0;
  logic [W-1:0] m_q     = '0;
  logic         m_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] lane(input int i);
    return bif.wdata[i*W +: W];
  endfunction

  task automatic set_lane(input int i, input logic [W-1:0] v);
    bif.wdata[i*W +: W] = v;
  endtask

  task automatic model_edge();
    if (clr) begin
      m_pend = -1; m_ptr = 0; m_owner = 0; m_q = '0; m_valid = 1'b0;
    end else if (m_pend >= 0) begin
      m_q     = lane(m_pend);
      m_owner = m_pend;
      m_valid = 1'b1;
      m_ptr   = (m_pend + 1) % N;
      m_pend  = -1;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (bif.req[(m_ptr + k) % N]) begin
          m_pend = (m_ptr + k) % N;
          break;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("gnt", 32'(bif.gnt), (m_pend >= 0) ? (32'd1 << m_pend) : 32'd0);
    chk("q", 32'(bif.q), 32'(m_q));
    chk("owner", 32'(bif.owner), 32'(m_owner));
    chk("valid", 32'(bif.valid), 32'(m_valid));
    $display("cyc t=%0t clr=%b req=%b gnt=%b q=%h owner=%0d valid=%b",
             $time, clr, bif.req, bif.gnt, bif.q, bif.owner, bif.valid);
  endtask

  logic [N-1:0] rot_gnt [10];
  bit           done [N];
  bit           prev_clr;

  initial begin
    rot_gnt = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    clr       = 1'b1;
    bif.req   = '1;
    bif.wdata = '0;
    @(negedge clk);

    // Reset held with all requesting
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_gnt", 32'(bif.gnt), 32'd0);
      chk("rst_valid", 32'(bif.valid), 32'd0);
    end

    // Single write
    clr     = 1'b0;
    bif.req = 4'b0100;
    set_lane(2, 8'hA5);
    step();
    chk("single_gnt", 32'(bif.gnt), 32'b0100);
    step();
    chk("single_q", 32'(bif.q), 32'hA5);
    chk("single_owner", 32'(bif.owner), 32'd2);
    bif.req = '0;
    step();

    // Rotation from ptr=0
    clr = 1'b1;
    step();
    clr     = 1'b0;
    bif.req = 4'b1111;
    for (int i = 0; i < N; i++) set_lane(i, 8'h10 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rot_gnt", 32'(bif.gnt), 32'(rot_gnt[i]));
      if (i % 2 == 1) chk("rot_q", 32'(bif.q), 32'h10 + 32'((i / 2) % 4));
    end
    bif.req = '0;
    step();

    // Wrap: winner 3 returns ptr to 0
    clr = 1'b1;
    step();
    clr     = 1'b0;
    bif.req = 4'b1000;
    step();
    chk("wrap_gnt3", 32'(bif.gnt), 32'b1000);
    step();
    bif.req = 4'b1001;
    step();
    chk("wrap_gnt0", 32'(bif.gnt), 32'b0001);
    step();
    step();
    chk("wrap_gnt3b", 32'(bif.gnt), 32'b1000);
    step();
    bif.req = '0;
    step();

    // Reset during WRITE
    clr     = 1'b1;
    step();
    clr     = 1'b0;
    bif.req = 4'b0010;
    set_lane(1, 8'h3C);
    step();
    chk("abort_gnt", 32'(bif.gnt), 32'b0010);
    clr = 1'b1;
    step();
    chk("abort_q", 32'(bif.q), 32'h00);
    chk("abort_valid", 32'(bif.valid), 32'd0);
    clr = 1'b0;
    step();
    chk("regrant_gnt", 32'(bif.gnt), 32'b0010);
    step();
    chk("regrant_q", 32'(bif.q), 32'h3C);
    bif.req = '0;
    step();

    // Data changed during WRITE is what gets captured
    bif.req = 4'b0010;
    set_lane(1, 8'h55);
    step();
    set_lane(1, 8'hAA);
    step();
    chk("stab_q", 32'(bif.q), 32'hAA);
    bif.req = '0;
    step();
    chk("stab_gnt_a", 32'(bif.gnt), 32'd0);
    step();
    chk("stab_gnt_b", 32'(bif.gnt), 32'd0);
    chk("stab_q2", 32'(bif.q), 32'hAA);

    // Random traffic obeying the requester rules
    for (int i = 0; i < N; i++) done[i] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      prev_clr = clr;
      for (int i = 0; i < N; i++) begin
        if (prev_clr) done[i] = 1'b0;
        if (done[i]) begin
          done[i] = 1'b0;
          if ($urandom_range(1) == 1) set_lane(i, 8'($urandom));
          else bif.req[i] = 1'b0;
        end else if (bif.req[i] && bif.gnt[i]) begin
          done[i] = 1'b1;
        end else if (!bif.req[i] && $urandom_range(3) == 0) begin
          bif.req[i] = 1'b1;
          set_lane(i, 8'($urandom));
        end
      end
      clr = ($urandom_range(99) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ff_write_arbiter.md
# ff_write_arbiter

Round-robin write arbiter that shares one W-bit synchronous-clear, enable-gated register between N requesters. It sequences the register's `ena`/`d` inputs so that exactly one requester's data is captured per grant and returns a one-cycle grant acknowledgement. It sits between the requesting datapath units and the bank of `flipflop_sync` cells that forms the shared register.

## Interface
- `N`, 4: number of requesters, ≥2.
- `W`, 8: register width in bits.

- `clk`  in  1  rising-edge clock.
- `clr`  in  1  synchronous active-high reset; also clears the shared register.
- `req`  in  N  per-requester write request; bit i belongs to requester i.
- `wdata`  in  N*W  packed write data; requester i owns bits [i*W +: W].
- `gnt`  out  N  one-hot grant/acknowledge, registered.
- `q`  out  W  shared register contents.
- `owner`  out  $clog2(N)  index of the last requester written.
- `valid`  out  1  high once any write has completed since reset.

## Operation
- Two-state FSM, `ARB` and `WRITE`; reset state `ARB`.
- `ARB`:
  - If `req` is nonzero at the edge, select the winner by round-robin starting at pointer `ptr`.
  - Latch the winner index, go to `WRITE`, and set `gnt[winner]` for the next cycle.
  - If `req` is zero, stay in `ARB`.
- `WRITE`:
  - Drive register `ena`=1 and `d`=`wdata[winner]` combinationally.
  - `gnt[winner]`=1 for this cycle only.
  - At the edge: `q` takes the data, `owner`=winner, `valid`=1, `ptr`=(winner+1) mod N, return to `ARB`.
- In every other state or cycle: register `ena`=0, `gnt`=0.
- Requester rules:
  - Hold `req` and `wdata` stable from assertion until the edge where it samples `gnt` high.
  - Drop `req` in the following cycle unless it has a new write.
  - Re-asserting `req` immediately is legal; it re-enters arbitration behind the others.
- Round-robin:
  - Search order is `ptr`, `ptr`+1, …, wrapping N-1→0.
  - A winner at index N-1 wraps `ptr` to 0.
- Register semantics: sync clear has priority over enable.

## Timing
- Reset values while `clr` is sampled high: `gnt`=0, `q`=0, `owner`=0, `valid`=0, `ptr`=0, state `ARB`.
- Write latency: `req` high in cycle 0 (FSM in `ARB`), `gnt` high in cycle 1, new `q` visible in cycle 2.
- Throughput is at most one write per 2 cycles; `gnt` is never high in two consecutive cycles.
- Simultaneous requests: exactly one grant per `WRITE`. With all N requesting continuously, grants rotate 0,1,…,N-1,0 when `ptr` starts at 0.
- `clr` during `WRITE`:
  - The write is aborted and `q`=0.
  - `gnt` is 0 from the next cycle.
  - `ptr`, `owner` and `valid` reset; state goes to `ARB`.
  - The requester keeps `req` high and is re-arbitrated after `clr` falls.
- `req` changes during `WRITE` have no effect on the current write. Only the latched winner's `wdata` is used.
- `wdata` of non-winning requesters is don't-care.

## Structure
- Package `ff_arb_pkg`: state enum `arb_state_t` {`ARB`, `WRITE`} and a localparam helper for the index width $clog2(N).
- Natural sub-module: the existing `flipflop_sync`.
  - Instantiate W copies via generate, one per bit.
  - Each copy has `clk`=`clk`, `clr`=`clr`, `ena`=write enable, `d`=selected bit.
  - Together they form `q`.
- Round-robin selection is a combinational function inside `ff_write_arbiter`, not a separate module.

## Test plan
- Reset: hold `clr`=1 for 2 cycles with `req`=4'b1111 → `gnt`=0, `q`=8'h00, `valid`=0, `owner`=0 throughout.
- Single write: after reset, `req`=4'b0100, `wdata[2]`=8'hA5 → `gnt`=4'b0100 one cycle later, `q`=8'hA5, `owner`=2, `valid`=1 one cycle after that.
- Rotation: `req`=4'b1111 held, `wdata[i]`=8'h10+i → `gnt` sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001; `q` follows 10,11,12,13,10.
- Wrap and pointer: grant requester 3 alone, then `req`=4'b1001 → requester 0 granted first, then 3.
- Reset mid-write: `req`=4'b0010 with data 8'h3C; assert `clr` on the `WRITE` cycle → `q` stays 8'h00, `valid`=0; after `clr` drops, requester 1 is granted and `q`=8'h3C.
- Data stability: change `wdata[1]` from 8'h55 to 8'hAA in `WRITE` while `req` stays high → `q` captures the value present during `WRITE`; no second write unless `req` persists past `gnt`.
